ahb_timer_slave: RTL and testbench
==================================

# ahb_timer_slave

AHB-Lite slave front end for the timer peripheral. Sits directly upstream of the timer core: it decodes AHB-Lite address and data phases into the core's `en`/`Addr`/`we`/`re`/`load`/`size` strobes. It returns the core's `counter_value` as `HRDATA` and generates OKAY/ERROR responses. Zero-wait-state for all legal transfers.

## Interface
- `ADDR_WIDTH`, 32: width of `HADDR`.
- `DATA_WIDTH`, 32: width of `HWDATA`/`HRDATA`/`load`/`counter_value`; equals the timer's counter width.
- `clk`  in  1  single clock for bus and core.
- `rst_n`  in  1  asynchronous, active-low reset.
- `HSEL`  in  1  slave select.
- `HADDR`  in  ADDR_WIDTH  byte address; only `[3:0]` decoded.
- `HTRANS`  in  2  transfer type; `HTRANS[1]`=1 means NONSEQ/SEQ.
- `HWRITE`  in  1  1=write.
- `HSIZE`  in  3  transfer size; only 3'b010 (word) is legal.
- `HWDATA`  in  DATA_WIDTH  write data, valid in data phase.
- `HREADY`  in  1  bus ready (previous transfer complete).
- `HRDATA`  out  DATA_WIDTH  read data.
- `HREADYOUT`  out  1  slave ready.
- `HRESP`  out  1  0=OKAY, 1=ERROR.
- `en`  out  1  core enable; core counts every cycle `en`=1 and `we`=0.
- `Addr`  out  2  core register index (`HADDR[3:2]` of the captured transfer).
- `we`  out  1  core write strobe.
- `re`  out  1  core read strobe.
- `load`  out  DATA_WIDTH  core write data.
- `size`  out  2  captured `HSIZE[1:0]`, passed through.
- `counter_value`  in  DATA_WIDTH  core read data (combinational from `Addr`/`re`).

## Operation
- Address-phase accept: `HSEL && HREADY && HTRANS[1]`. On accept, register `HADDR[3:2]`, `HWRITE` and `HSIZE`, plus an illegal flag.
- Illegal flag is set for any of:
  - `HADDR[1:0]`≠0;
  - `HSIZE`≠3'b010;
  - a write with `HADDR[3:2]`=2'b11 (read-only status register).
- FSM states: IDLE, WR, RD, ERR1, ERR2. The next state is computed at every edge where `HREADYOUT`=1.
  - Accept of a legal write → WR.
  - Accept of a legal read → RD.
  - Accept of an illegal transfer → ERR1.
  - No accept → IDLE.
  - ERR1 → ERR2 unconditionally. In ERR1, `HREADYOUT`=0, so no new address is sampled.
- Core drive:
  - WR: `we`=1, `load`=`HWDATA`.
  - RD: `re`=1.
  - All other states: `we`=`re`=0, `load`=0.
  - `Addr` and `size` hold the captured values in every state.
- `en`: register, 0 in reset, 1 from the first `clk` edge after `rst_n` deasserts, then held at 1.
- Bus response:
  - IDLE/WR/RD: `HREADYOUT`=1, `HRESP`=0.
  - ERR1: `HREADYOUT`=0, `HRESP`=1.
  - ERR2: `HREADYOUT`=1, `HRESP`=1.
- `HRDATA` = `counter_value` in RD, else 0.
- An illegal transfer never asserts `we` or `re`.
- BUSY/IDLE `HTRANS`, or `HSEL`=0: no accept, and an OKAY response.

## Timing
- Reset values:
  - FSM = IDLE;
  - `HREADYOUT`=1, `HRESP`=0, `HRDATA`=0;
  - `en`=0, `we`=0, `re`=0, `Addr`=0, `size`=0, `load`=0.
- Write: address phase at edge N; `we` high for the whole cycle N..N+1; the core captures `load` at edge N+1.
- Read: address phase at edge N; `re` high and `HRDATA` valid during cycle N..N+1; the master samples at edge N+1.
- Back-to-back transfers: the data phase of transfer k overlaps the address phase of k+1. No bubble between them; a read after a write to the same register returns the new value.
- An error costs exactly 2 data-phase cycles (ERR1, ERR2). The address phase is sampled normally in ERR2.
- Reset asserted mid-transfer: outputs return to reset values asynchronously, and the transfer is dropped.

## Configuration
- `TIMER_AHB_ERR_EN` defined: illegal transfers get the two-cycle ERROR response described above.
- `TIMER_AHB_ERR_EN` undefined: illegal transfers go to IDLE instead of ERR1, with a zero-wait OKAY response.
  - The core is still not strobed.
  - Illegal reads return `HRDATA`=0.
  - ERR1/ERR2 are unreachable.

## Test plan
- Reset: hold `rst_n`=0 → `HREADYOUT`=1, `HRESP`=0, `en`=0, `we`=0, `re`=0. Release → `en`=1 after one edge.
- Write 0x0000_0005 to 0x4, then write 0x0000_0010 to 0x0 back-to-back:
  - `we`=1 with `Addr`=1, `load`=5 in cycle 1;
  - `we`=1 with `Addr`=0, `load`=0x10 in cycle 2;
  - both complete with OKAY and zero wait.
- Write 0x20 to 0x0, then immediately read 0x0 → `re`=1 with `Addr`=0, `HRDATA`=0x20 in the read data phase.
- Write to 0xC (with `TIMER_AHB_ERR_EN`):
  - `we` never asserts;
  - `HREADYOUT`/`HRESP` sequence is 0/1 then 1/1;
  - a following legal read of 0xC completes with OKAY.
- Halfword read at 0x2 (`HSIZE`=3'b001):
  - with `TIMER_AHB_ERR_EN`: ERROR, `re`=0;
  - without `TIMER_AHB_ERR_EN`: OKAY, `HRDATA`=0, `re`=0.
- Assert `rst_n`=0 during ERR1 → immediate `HREADYOUT`=1, `HRESP`=0, FSM IDLE; the next legal write succeeds.

Source files
------------

// File: rtl/ahb_timer_slave_if.sv
// AHB-Lite bus bundle between a master and the timer slave front end.
interface ahb_timer_slave_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  HSEL;
    logic [ADDR_WIDTH-1:0] HADDR;
    logic [1:0]            HTRANS;
    logic                  HWRITE;
    logic [2:0]            HSIZE;
    logic [DATA_WIDTH-1:0] HWDATA;
    logic                  HREADY;
    logic [DATA_WIDTH-1:0] HRDATA;
    logic                  HREADYOUT;
    logic                  HRESP;

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
        input  HRDATA, HREADYOUT, HRESP
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
        output HRDATA, HREADYOUT, HRESP
    );
endinterface

// File: rtl/ahb_timer_slave.sv
// AHB-Lite slave front end for the timer core: decodes bus phases into core strobes.
// Define TIMER_AHB_ERR_EN for the two-cycle ERROR response on illegal transfers.
module ahb_timer_slave #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    ahb_timer_slave_if.slave      bus,
    output logic                  en,
    output logic [1:0]            Addr,
    output logic                  we,
    output logic                  re,
    output logic [DATA_WIDTH-1:0] load,
    output logic [1:0]            size,
    input  logic [DATA_WIDTH-1:0] counter_value
);
    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] WR   = 3'd1;
    localparam logic [2:0] RD   = 3'd2;
    localparam logic [2:0] ERR1 = 3'd3;
    localparam logic [2:0] ERR2 = 3'd4;

    logic [2:0] state, state_nxt;
    logic       accept;
    logic       illegal;
    logic       unused_bits;

    assign unused_bits = ^{bus.HADDR[ADDR_WIDTH-1:4], bus.HTRANS[0]};

    // ERR1 holds the bus, so nothing is sampled there even if HREADY is mis-wired.
    assign accept  = bus.HSEL && bus.HREADY && bus.HTRANS[1] && (state != ERR1);
    assign illegal = (bus.HADDR[1:0] != 2'b00) || (bus.HSIZE != 3'b010) ||
                     (bus.HWRITE && (bus.HADDR[3:2] == 2'b11));

    always_comb begin
        state_nxt = IDLE;
        if (state == ERR1) begin
            state_nxt = ERR2;
        end else if (accept) begin
            if (illegal) begin
`ifdef TIMER_AHB_ERR_EN
                state_nxt = ERR1;
`else
                state_nxt = IDLE;
`endif
            end else begin
                state_nxt = bus.HWRITE ? WR : RD;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            Addr  <= 2'b00;
            size  <= 2'b00;
            en    <= 1'b0;
        end else begin
            state <= state_nxt;
            en    <= 1'b1;
            if (accept) begin
                Addr <= bus.HADDR[3:2];
                size <= bus.HSIZE[1:0];
            end
        end
    end

    // All data-phase outputs decode straight from state so reset clears them asynchronously.
    assign we            = (state == WR);
    assign re            = (state == RD);
    assign load          = we ? bus.HWDATA : '0;
    assign bus.HRDATA    = re ? counter_value : '0;
    assign bus.HREADYOUT = (state != ERR1);
    assign bus.HRESP     = (state == ERR1) || (state == ERR2);
endmodule

// File: tb/tb_ahb_timer_slave.sv
// Directed bench for ahb_timer_slave with a per-cycle expectation scoreboard.
module tb_ahb_timer_slave;
    localparam logic [31:0] STATUS = 32'hA5A5_0003;

    logic        clk;
    logic        rst_n;
    logic        en, we, re;
    logic [1:0]  Addr, size;
    logic [31:0] load, counter_value;
    logic [31:0] core_regs [0:3];

    ahb_timer_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    ahb_timer_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .en(en), .Addr(Addr), .we(we),
        .re(re), .load(load), .size(size), .counter_value(counter_value)
    );

    assign bus.HREADY = bus.HREADYOUT;

    // Minimal timer core: plain registers, status at index 3.
    always @(posedge clk) if (we) core_regs[Addr] <= load;
    assign counter_value = !re ? 32'h0 : (Addr == 2'd3) ? STATUS : core_regs[Addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic        rdy, resp, we, re;
        logic [1:0]  addr, size;
        logic [31:0] load, rdata;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_regs [0:3];
    logic        cur_err1;
    logic [1:0]  m_addr, m_size;
    logic [31:0] pend_wd;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Expected data-phase behaviour for the cycle following the current address phase.
    task automatic push_next(input logic sel, input logic [1:0] tr, input logic wr,
                             input logic [2:0] sz, input logic [31:0] ad,
                             input logic [31:0] wd, input string tag);
        exp_t e;
        logic legal;
        e.tag = tag; e.rdy = 1'b1; e.resp = 1'b0; e.we = 1'b0; e.re = 1'b0;
        e.load = 32'h0; e.rdata = 32'h0;
        if (cur_err1) begin
            e.resp   = 1'b1;
            cur_err1 = 1'b0;
        end else if (sel && tr[1]) begin
            m_addr = ad[3:2];
            m_size = sz[1:0];
            legal  = (ad[1:0] == 2'b00) && (sz == 3'b010) && !(wr && ad[3:2] == 2'b11);
            if (!legal) begin
`ifdef TIMER_AHB_ERR_EN
                e.rdy = 1'b0; e.resp = 1'b1; cur_err1 = 1'b1;
`endif
            end else if (wr) begin
                e.we = 1'b1; e.load = wd; m_regs[ad[3:2]] = wd;
            end else begin
                e.re = 1'b1; e.rdata = m_regs[ad[3:2]];
            end
        end
        e.addr = m_addr;
        e.size = m_size;
        q.push_back(e);
    endtask

    task automatic check_pop();
        exp_t e;
        checks++;
        assert (q.size() != 0) else begin
            errors++;
            $error("FAIL queue_empty got=0 exp=1");
        end
        if (q.size() != 0) begin
            e = q.pop_front();
            chk({e.tag, "/rdy"},   32'(bus.HREADYOUT), 32'(e.rdy));
            chk({e.tag, "/resp"},  32'(bus.HRESP),     32'(e.resp));
            chk({e.tag, "/we"},    32'(we),            32'(e.we));
            chk({e.tag, "/re"},    32'(re),            32'(e.re));
            chk({e.tag, "/addr"},  32'(Addr),          32'(e.addr));
            chk({e.tag, "/size"},  32'(size),          32'(e.size));
            chk({e.tag, "/load"},  load,               e.load);
            chk({e.tag, "/rdata"}, bus.HRDATA,         e.rdata);
            chk({e.tag, "/en"},    32'(en),            32'd1);
        end
    endtask

    // Entered just after a rising edge; leaves just after the next one.
    task automatic step(input logic sel, input logic [1:0] tr, input logic wr,
                        input logic [2:0] sz, input logic [31:0] ad,
                        input logic [31:0] wd, input string tag);
        bus.HWDATA = pend_wd;
        bus.HSEL = sel; bus.HTRANS = tr; bus.HWRITE = wr; bus.HSIZE = sz; bus.HADDR = ad;
        @(negedge clk);
        check_pop();
        push_next(sel, tr, wr, sz, ad, wd, tag);
        pend_wd = wd;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input string tag);
        step(1'b0, 2'b00, 1'b0, 3'b010, 32'h0, 32'h0, tag);
    endtask

    task automatic reset_outputs(input string tag);
        chk({tag, "/rdy"},   32'(bus.HREADYOUT), 32'd1);
        chk({tag, "/resp"},  32'(bus.HRESP),     32'd0);
        chk({tag, "/en"},    32'(en),            32'd0);
        chk({tag, "/we"},    32'(we),            32'd0);
        chk({tag, "/re"},    32'(re),            32'd0);
        chk({tag, "/rdata"}, bus.HRDATA,         32'h0);
        chk({tag, "/addr"},  32'(Addr),          32'd0);
        chk({tag, "/load"},  load,               32'h0);
    endtask

    // Called between a falling and rising edge while rst_n is low.
    task automatic release_reset();
        bus.HSEL = 1'b0; bus.HTRANS = 2'b00; bus.HWDATA = 32'h0;
        q.delete();
        cur_err1 = 1'b0; m_addr = 2'b00; m_size = 2'b00; pend_wd = 32'h0;
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("en_after_release", 32'(en), 32'd1);
        push_next(1'b0, 2'b00, 1'b0, 3'b010, 32'h0, 32'h0, "post_rst");
    endtask

    initial begin
        m_regs[0] = 32'h0; m_regs[1] = 32'h0; m_regs[2] = 32'h0; m_regs[3] = STATUS;
        cur_err1 = 1'b0; m_addr = 2'b00; m_size = 2'b00; pend_wd = 32'h0;
        bus.HSEL = 1'b0; bus.HADDR = 32'h0; bus.HTRANS = 2'b00; bus.HWRITE = 1'b0;
        bus.HSIZE = 3'b010; bus.HWDATA = 32'h0;
        rst_n = 1'b0;

        #12;
        reset_outputs("reset");
        release_reset();

        // Back-to-back writes, then write-then-read of the same register.
        step(1'b1, 2'b10, 1'b1, 3'b010, 32'h4, 32'h5,  "wr4");
        step(1'b1, 2'b10, 1'b1, 3'b010, 32'h0, 32'h10, "wr0");
        step(1'b1, 2'b10, 1'b1, 3'b010, 32'h0, 32'h20, "wr0b");
        step(1'b1, 2'b10, 1'b0, 3'b010, 32'h0, 32'h0,  "rd0");

        // Write to the read-only status register; the following read is held through ERR1.
        step(1'b1, 2'b10, 1'b1, 3'b010, 32'hC, 32'h55, "wrC");
`ifdef TIMER_AHB_ERR_EN
        step(1'b1, 2'b10, 1'b0, 3'b010, 32'hC, 32'h0,  "err2");
`endif
        step(1'b1, 2'b10, 1'b0, 3'b010, 32'hC, 32'h0,  "rdC");

        step(1'b1, 2'b10, 1'b0, 3'b001, 32'h2, 32'h0,  "rd_hw");
        idle("hw_done");
`ifdef TIMER_AHB_ERR_EN
        idle("hw_err2");
`endif
        step(1'b1, 2'b10, 1'b0, 3'b010, 32'h4, 32'h0,  "rd4");
        step(1'b1, 2'b01, 1'b1, 3'b010, 32'h0, 32'hFF, "busy");
        step(1'b0, 2'b10, 1'b1, 3'b010, 32'h0, 32'hFF, "nosel");
        step(1'b1, 2'b10, 1'b0, 3'b010, 32'h0, 32'h0,  "rd0c");
        idle("idle0");

        // Reset asserted in the middle of a data phase.
`ifdef TIMER_AHB_ERR_EN
        step(1'b1, 2'b10, 1'b1, 3'b010, 32'hC, 32'h99, "rst_err1");
`else
        step(1'b1, 2'b10, 1'b1, 3'b010, 32'h8, 32'h99, "rst_wr");
`endif
        bus.HWDATA = pend_wd; bus.HTRANS = 2'b00; bus.HSEL = 1'b0;
        @(negedge clk);
        check_pop();
        #2 rst_n = 1'b0;
        #1;
        reset_outputs("mid_reset");
        release_reset();

        step(1'b1, 2'b10, 1'b1, 3'b010, 32'h8, 32'h77, "wr8");
        step(1'b1, 2'b10, 1'b0, 3'b010, 32'h8, 32'h0,  "rd8");
        idle("tail");
        @(negedge clk);
        check_pop();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
